pc_chain_master: RTL and testbench

//  Owns the head of the performance-counter (pc) ring threaded through all Gorilla++ engines.

---
 rtl/pc_chain_master_if.sv | 59 +++++
 rtl/pc_chain_master.sv | 204 ++++++++++++++++++++
 tb/tb_pc_chain_master.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/pc_chain_master_if.sv
// ---- pc_chain_master_if : host command/response and pc ring bundle -- rev 1.0 ----
`default_nettype none

interface pc_chain_master_if;
  logic        io_cmd_valid;
  logic        io_cmd_ready;
  logic [1:0]  io_cmd_bits_op;
  logic [15:0] io_cmd_bits_moduleId;
  logic [7:0]  io_cmd_bits_portId;
  logic        io_pcOut_valid;
  logic        io_pcOut_bits_request;
  logic [15:0] io_pcOut_bits_moduleId;
  logic [7:0]  io_pcOut_bits_portId;
  logic [15:0] io_pcOut_bits_pcValue;
  logic [3:0]  io_pcOut_bits_pcType;
  logic        io_pcIn_valid;
  logic        io_pcIn_bits_request;
  logic [15:0] io_pcIn_bits_moduleId;
  logic [7:0]  io_pcIn_bits_portId;
  logic [15:0] io_pcIn_bits_pcValue;
  logic [3:0]  io_pcIn_bits_pcType;
  logic        io_rsp_valid;
  logic        io_rsp_ready;
  logic [15:0] io_rsp_bits_moduleId;
  logic [7:0]  io_rsp_bits_portId;
  logic [15:0] io_rsp_bits_pcValue;
  logic [1:0]  io_rsp_bits_status;
  logic        io_rsp_bits_last;
  logic        io_busy;
  logic        io_stray;

  modport master (
    input  io_cmd_valid, io_cmd_bits_op, io_cmd_bits_moduleId, io_cmd_bits_portId,
    output io_cmd_ready,
    output io_pcOut_valid, io_pcOut_bits_request, io_pcOut_bits_moduleId,
           io_pcOut_bits_portId, io_pcOut_bits_pcValue, io_pcOut_bits_pcType,
    input  io_pcIn_valid, io_pcIn_bits_request, io_pcIn_bits_moduleId,
           io_pcIn_bits_portId, io_pcIn_bits_pcValue, io_pcIn_bits_pcType,
    output io_rsp_valid, io_rsp_bits_moduleId, io_rsp_bits_portId,
           io_rsp_bits_pcValue, io_rsp_bits_status, io_rsp_bits_last,
    input  io_rsp_ready,
    output io_busy, io_stray
  );

  modport slave (
    output io_cmd_valid, io_cmd_bits_op, io_cmd_bits_moduleId, io_cmd_bits_portId,
    input  io_cmd_ready,
    input  io_pcOut_valid, io_pcOut_bits_request, io_pcOut_bits_moduleId,
           io_pcOut_bits_portId, io_pcOut_bits_pcValue, io_pcOut_bits_pcType,
    output io_pcIn_valid, io_pcIn_bits_request, io_pcIn_bits_moduleId,
           io_pcIn_bits_portId, io_pcIn_bits_pcValue, io_pcIn_bits_pcType,
    input  io_rsp_valid, io_rsp_bits_moduleId, io_rsp_bits_portId,
           io_rsp_bits_pcValue, io_rsp_bits_status, io_rsp_bits_last,
    output io_rsp_ready,
    input  io_busy, io_stray
  );
endinterface

`default_nettype wire

// File: rtl/pc_chain_master.sv
// ---- pc_chain_master : head of the perf-counter ring, one outstanding request -- rev 1.0 ----
`default_nettype none

module pc_chain_master #(
  parameter int unsigned NUM_MODULES     = 8,
  parameter int unsigned FIRST_MODULE_ID = 1,
  parameter int unsigned NUM_PORTS       = 2,
  parameter int unsigned TIMEOUT         = 255
) (
  input  logic               clk,
  input  logic               reset,
  pc_chain_master_if.master  bus
);
  localparam int unsigned       CNT_W     = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [15:0]       FIRST_MOD = 16'(FIRST_MODULE_ID);
  localparam logic [15:0]       LAST_MOD  = 16'(FIRST_MODULE_ID + NUM_MODULES - 1);
  localparam logic [7:0]        LAST_PORT = 8'(NUM_PORTS - 1);
  localparam logic [1:0]        OP_SWEEP  = 2'd0;
  localparam logic [1:0]        OP_SINGLE = 2'd1;
  localparam logic [1:0]        OP_CLEAR  = 2'd2;
  localparam logic [3:0]        PC_READ   = 4'd0;
  localparam logic [3:0]        PC_CLEAR  = 4'd2;
  localparam logic [1:0]        ST_OK     = 2'd0;
  localparam logic [1:0]        ST_TMO    = 2'd1;
  localparam logic [1:0]        ST_NORSP  = 2'd2;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_RESPOND = 2'd3} state_e;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [15:0]       mod_q, mod_d;
  logic [7:0]        port_q, port_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pco_valid_q, pco_valid_d;
  logic              pco_req_q, pco_req_d;
  logic [15:0]       pco_mod_q, pco_mod_d;
  logic [7:0]        pco_port_q, pco_port_d;
  logic [3:0]        pco_type_q, pco_type_d;
  logic [15:0]       rsp_value_q, rsp_value_d;
  logic [1:0]        rsp_status_q, rsp_status_d;
  logic              rsp_last_q, rsp_last_d;
  logic              stray_q, stray_d;

  logic w_match;
  logic w_last;

  assign w_match = bus.io_pcIn_valid && (bus.io_pcIn_bits_moduleId == mod_q)
                   && (bus.io_pcIn_bits_portId == port_q);
  assign w_last  = (op_q != OP_SWEEP) || ((mod_q == LAST_MOD) && (port_q == LAST_PORT));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      mod_q        <= '0;
      port_q       <= '0;
      cnt_q        <= '0;
      pco_valid_q  <= 1'b0;
      pco_req_q    <= 1'b0;
      pco_mod_q    <= '0;
      pco_port_q   <= '0;
      pco_type_q   <= '0;
      rsp_value_q  <= '0;
      rsp_status_q <= '0;
      rsp_last_q   <= 1'b0;
      stray_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      mod_q        <= mod_d;
      port_q       <= port_d;
      cnt_q        <= cnt_d;
      pco_valid_q  <= pco_valid_d;
      pco_req_q    <= pco_req_d;
      pco_mod_q    <= pco_mod_d;
      pco_port_q   <= pco_port_d;
      pco_type_q   <= pco_type_d;
      rsp_value_q  <= rsp_value_d;
      rsp_status_q <= rsp_status_d;
      rsp_last_q   <= rsp_last_d;
      stray_q      <= stray_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    mod_d        = mod_q;
    port_d       = port_q;
    cnt_d        = cnt_q;
    pco_valid_d  = 1'b0;
    pco_req_d    = pco_req_q;
    pco_mod_d    = pco_mod_q;
    pco_port_d   = pco_port_q;
    pco_type_d   = pco_type_q;
    rsp_value_d  = rsp_value_q;
    rsp_status_d = rsp_status_q;
    rsp_last_d   = rsp_last_q;
    // Every ring packet is stray unless WAIT consumes it below.
    stray_d      = bus.io_pcIn_valid;

    case (state_q)
      S_IDLE: begin
        if (bus.io_cmd_valid) begin
          op_d = bus.io_cmd_bits_op;
          case (bus.io_cmd_bits_op)
            OP_SWEEP: begin
              mod_d   = FIRST_MOD;
              port_d  = 8'd0;
              state_d = S_ISSUE;
            end
            OP_SINGLE: begin
              mod_d   = bus.io_cmd_bits_moduleId;
              port_d  = bus.io_cmd_bits_portId;
              state_d = S_ISSUE;
            end
            OP_CLEAR: begin
              mod_d   = 16'hFFFF;
              port_d  = 8'd0;
              state_d = S_ISSUE;
            end
            default: begin
              mod_d        = bus.io_cmd_bits_moduleId;
              port_d       = bus.io_cmd_bits_portId;
              rsp_value_d  = 16'd0;
              rsp_status_d = ST_NORSP;
              rsp_last_d   = 1'b1;
              state_d      = S_RESPOND;
            end
          endcase
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (w_match) begin
          stray_d    = 1'b0;
          rsp_last_d = w_last;
          state_d    = S_RESPOND;
          // A clear finishes when its own broadcast packet comes home.
          if (op_q == OP_CLEAR) begin
            rsp_status_d = ST_OK;
            rsp_value_d  = 16'd0;
          end else if (bus.io_pcIn_bits_request) begin
            rsp_status_d = ST_NORSP;
            rsp_value_d  = 16'd0;
          end else begin
            rsp_status_d = ST_OK;
            rsp_value_d  = bus.io_pcIn_bits_pcValue;
          end
        end else if (cnt_d == TIMEOUT_C) begin
          rsp_status_d = ST_TMO;
          rsp_value_d  = 16'd0;
          rsp_last_d   = w_last;
          state_d      = S_RESPOND;
        end
      end
      S_RESPOND: begin
        if (bus.io_rsp_ready) begin
          if (rsp_last_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_ISSUE;
            if (port_q == LAST_PORT) begin
              port_d = 8'd0;
              mod_d  = mod_q + 16'd1;
            end else begin
              port_d = port_q + 8'd1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_ISSUE) begin
      pco_valid_d = 1'b1;
      pco_req_d   = 1'b1;
      pco_mod_d   = mod_d;
      pco_port_d  = port_d;
      pco_type_d  = (op_d == OP_CLEAR) ? PC_CLEAR : PC_READ;
      cnt_d       = '0;
    end
  end

  assign bus.io_cmd_ready           = (state_q == S_IDLE);
  assign bus.io_busy                = (state_q != S_IDLE);
  assign bus.io_stray               = stray_q;
  assign bus.io_pcOut_valid         = pco_valid_q;
  assign bus.io_pcOut_bits_request  = pco_req_q;
  assign bus.io_pcOut_bits_moduleId = pco_mod_q;
  assign bus.io_pcOut_bits_portId   = pco_port_q;
  assign bus.io_pcOut_bits_pcValue  = 16'd0;
  assign bus.io_pcOut_bits_pcType   = pco_type_q;
  assign bus.io_rsp_valid           = (state_q == S_RESPOND);
  assign bus.io_rsp_bits_moduleId   = mod_q;
  assign bus.io_rsp_bits_portId     = port_q;
  assign bus.io_rsp_bits_pcValue    = rsp_value_q;
  assign bus.io_rsp_bits_status     = rsp_status_q;
  assign bus.io_rsp_bits_last       = rsp_last_q;
endmodule

`default_nettype wire

// File: tb/tb_pc_chain_master.sv
// ---- tb_pc_chain_master : directed checks of the pc ring master -- rev 1.0 ----
`default_nettype none

module tb_pc_chain_master;
  localparam int TIMEOUT = 20;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   pc_issues = 0;
  int   strays = 0;

  pc_chain_master_if bus ();

  pc_chain_master #(
    .NUM_MODULES(2), .FIRST_MODULE_ID(1), .NUM_PORTS(2), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.io_pcOut_valid) pc_issues++;
    if (bus.io_stray) strays++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rsp_now();
    return {21'd0, bus.io_rsp_bits_moduleId, bus.io_rsp_bits_portId,
            bus.io_rsp_bits_pcValue, bus.io_rsp_bits_status, bus.io_rsp_bits_last};
  endfunction

  function automatic logic [63:0] pco_now();
    return {30'd0, bus.io_pcOut_valid, bus.io_pcOut_bits_request, bus.io_pcOut_bits_moduleId,
            bus.io_pcOut_bits_portId, bus.io_pcOut_bits_pcValue, bus.io_pcOut_bits_pcType};
  endfunction

  task automatic send_cmd(input logic [1:0] op, input logic [15:0] m, input logic [7:0] p);
    bus.io_cmd_valid         = 1'b1;
    bus.io_cmd_bits_op       = op;
    bus.io_cmd_bits_moduleId = m;
    bus.io_cmd_bits_portId   = p;
    tick();
    bus.io_cmd_valid         = 1'b0;
  endtask

  task automatic ring_pkt(input logic req, input logic [15:0] m, input logic [7:0] p,
                          input logic [15:0] v);
    bus.io_pcIn_valid         = 1'b1;
    bus.io_pcIn_bits_request  = req;
    bus.io_pcIn_bits_moduleId = m;
    bus.io_pcIn_bits_portId   = p;
    bus.io_pcIn_bits_pcValue  = v;
    tick();
    bus.io_pcIn_valid         = 1'b0;
  endtask

  task automatic wait_pcout(input string tag);
    int n = 0;
    while (!bus.io_pcOut_valid && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_pcout_valid"}, 64'(bus.io_pcOut_valid), 64'd1);
  endtask

  task automatic expect_rsp(input string tag, input logic [15:0] m, input logic [7:0] p,
                            input logic [15:0] v, input logic [1:0] st, input logic last,
                            input int hold);
    int n = 0;
    logic [63:0] exp;
    exp = {21'd0, m, p, v, st, last};
    while (!bus.io_rsp_valid && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_rsp_valid"}, 64'(bus.io_rsp_valid), 64'd1);
    check({tag, "_rsp"}, rsp_now(), exp);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold"}, {bus.io_rsp_valid, rsp_now()[62:0]}, {1'b1, exp[62:0]});
    end
    bus.io_rsp_ready = 1'b1;
    tick();
    bus.io_rsp_ready = 1'b0;
  endtask

  initial begin
    int p0, p1, s0, n;
    bus.io_cmd_valid          = 1'b0;
    bus.io_cmd_bits_op        = 2'd0;
    bus.io_cmd_bits_moduleId  = 16'd0;
    bus.io_cmd_bits_portId    = 8'd0;
    bus.io_pcIn_valid         = 1'b0;
    bus.io_pcIn_bits_request  = 1'b0;
    bus.io_pcIn_bits_moduleId = 16'd0;
    bus.io_pcIn_bits_portId   = 8'd0;
    bus.io_pcIn_bits_pcValue  = 16'd0;
    bus.io_pcIn_bits_pcType   = 4'd0;
    bus.io_rsp_ready          = 1'b0;

    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("reset_ready", 64'(bus.io_cmd_ready), 64'd1);
    check("reset_busy", 64'(bus.io_busy), 64'd0);
    check("reset_pcout", pco_now(), 64'd0);
    check("reset_rsp", {bus.io_rsp_valid, bus.io_stray, rsp_now()[61:0]}, 64'd0);

    // Single read (5,1) answered after three cycles.
    p0 = pc_issues;
    send_cmd(2'd1, 16'd5, 8'd1);
    check("t1_pcout", pco_now(), {30'd0, 1'b1, 1'b1, 16'd5, 8'd1, 16'd0, 4'd0});
    tick();
    check("t1_pcout_drop", pco_now(), {30'd0, 1'b0, 1'b1, 16'd5, 8'd1, 16'd0, 4'd0});
    check("t1_busy", 64'(bus.io_busy), 64'd1);
    tick();
    ring_pkt(1'b0, 16'd5, 8'd1, 16'h002A);
    expect_rsp("t1", 16'd5, 8'd1, 16'h002A, 2'd0, 1'b1, 0);
    check("t1_issues", 64'(pc_issues - p0), 64'd1);
    check("t1_idle", 64'(bus.io_busy), 64'd0);

    // Sweep over modules 1..2, ports 0..1; first result held back for ten cycles.
    p0 = pc_issues;
    send_cmd(2'd0, 16'd0, 8'd0);
    for (int m = 1; m <= 2; m++) begin
      for (int p = 0; p <= 1; p++) begin
        wait_pcout("t2");
        check("t2_target", {bus.io_pcOut_bits_moduleId, bus.io_pcOut_bits_portId,
                            bus.io_pcOut_bits_pcType}, {16'(m), 8'(p), 4'd0});
        tick();
        ring_pkt(1'b0, 16'(m), 8'(p), 16'(m * 10 + p));
        if (m == 1 && p == 0) begin
          p1 = pc_issues;
          expect_rsp("t5", 16'(m), 8'(p), 16'(m * 10 + p), 2'd0, 1'b0, 10);
          check("t5_no_issue", 64'(pc_issues - p1), 64'd0);
        end else begin
          expect_rsp("t2", 16'(m), 8'(p), 16'(m * 10 + p), 2'd0, (m == 2 && p == 1), 0);
        end
      end
    end
    check("t2_issues", 64'(pc_issues - p0), 64'd4);
    check("t2_idle", 64'(bus.io_busy), 64'd0);

    // Dropped request times out exactly TIMEOUT cycles after WAIT entry.
    send_cmd(2'd1, 16'd7, 8'd0);
    tick();
    n = 0;
    while (!bus.io_rsp_valid && n < 100) begin
      tick();
      n++;
    end
    check("t3_latency", 64'(n), 64'(TIMEOUT));
    expect_rsp("t3", 16'd7, 8'd0, 16'd0, 2'd1, 1'b1, 0);
    check("t3_idle", 64'(bus.io_busy), 64'd0);

    // Unanswered request returns unchanged; then clear-all; then illegal op.
    send_cmd(2'd1, 16'd3, 8'd2);
    tick();
    ring_pkt(1'b1, 16'd3, 8'd2, 16'h1234);
    expect_rsp("t4_norsp", 16'd3, 8'd2, 16'd0, 2'd2, 1'b1, 0);
    send_cmd(2'd2, 16'd0, 8'd0);
    check("t4_clear_pcout", pco_now(), {30'd0, 1'b1, 1'b1, 16'hFFFF, 8'd0, 16'd0, 4'd2});
    tick();
    ring_pkt(1'b1, 16'hFFFF, 8'd0, 16'd0);
    expect_rsp("t4_clear", 16'hFFFF, 8'd0, 16'd0, 2'd0, 1'b1, 0);
    p0 = pc_issues;
    send_cmd(2'd3, 16'd9, 8'd4);
    expect_rsp("t4_illegal", 16'd9, 8'd4, 16'd0, 2'd2, 1'b1, 0);
    tick();
    check("t4_illegal_no_issue", 64'(pc_issues - p0), 64'd0);

    // Stray packet during WAIT, then reset mid-WAIT.
    s0 = strays;
    send_cmd(2'd1, 16'd6, 8'd1);
    tick();
    ring_pkt(1'b0, 16'd9, 8'd0, 16'd77);
    check("t6_stray_pulse", 64'(bus.io_stray), 64'd1);
    check("t6_still_busy", 64'(bus.io_busy), 64'd1);
    tick();
    check("t6_stray_end", 64'(bus.io_stray), 64'd0);
    check("t6_stray_count", 64'(strays - s0), 64'd1);
    reset = 1'b0;
    tick();
    check("t6_reset_ctrl", {bus.io_cmd_ready, bus.io_busy, bus.io_rsp_valid, bus.io_stray},
          {1'b1, 1'b0, 1'b0, 1'b0});
    check("t6_reset_pcout", pco_now(), 64'd0);
    check("t6_reset_rsp", rsp_now(), 64'd0);
    reset = 1'b1;
    tick();
    ring_pkt(1'b0, 16'd6, 8'd1, 16'd5);
    check("t6_late_stray", {bus.io_stray, bus.io_rsp_valid, bus.io_busy}, {1'b1, 1'b0, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
